addertree_result_accumulator: RTL and testbench

//  Receiving end of the adder-tree pipeline. Takes carry-save (sum, carry) vectors from the

---
 rtl/npu_acc_pkg.sv | 44 ++++
 rtl/acc_requant.sv | 43 ++++
 rtl/addertree_result_accumulator.sv | 131 +++++++++++++
 tb/tb_addertree_result_accumulator.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_acc_pkg.sv
// ----------------------------------------------------------------------------
// npu_acc_pkg
// Shared constants and helpers for the adder-tree result accumulator.
//   DEF_IN_W / DEF_ACC_W / DEF_OUT_W : default datapath widths
//   SHIFT_W                          : width of the requant shift control
//   CNT_W                            : width of the per-window beat counter
//   wide_t                           : 64-bit signed scratch type for exact
//                                      intermediate arithmetic
//   sext()       : sign-extend the low w bits of a vector to wide_t
//   sat_signed() : clamp a wide_t to the range of a w-bit signed number
// ----------------------------------------------------------------------------
package npu_acc_pkg;

    localparam int unsigned DEF_IN_W  = 20;
    localparam int unsigned DEF_ACC_W = 32;
    localparam int unsigned DEF_OUT_W = 8;
    localparam int unsigned SHIFT_W   = 5;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned WIDE_W    = 64;

    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic wide_t sext(input logic [WIDE_W-1:0] v, input int unsigned w);
        wide_t t;
        t = wide_t'(v << (WIDE_W - w));
        return t >>> (WIDE_W - w);
    endfunction

    function automatic wide_t sat_signed(input wide_t v, input int unsigned w);
        wide_t hi;
        wide_t lo;
        wide_t r;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (w - 1));
        r  = v;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_requant.sv
// ----------------------------------------------------------------------------
// acc_requant
// Combinational requantiser: round half-up, arithmetic right shift, optional
// ReLU and saturation of a signed accumulator to the output width.
//   acc    in  ACC_W    signed accumulated total
//   shift  in  SHIFT_W  right-shift amount (0 = no rounding bias)
//   relu   in  1        clamp negative results to zero
//   result out OUT_W    signed requantised value
// ----------------------------------------------------------------------------
module acc_requant
    import npu_acc_pkg::*;
#(
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned OUT_W = DEF_OUT_W
) (
    input  logic signed [ACC_W-1:0]   acc,
    input  logic        [SHIFT_W-1:0] shift,
    input  logic                      relu,
    output logic signed [OUT_W-1:0]   result
);

    wide_t biased;
    wide_t rounded;
    wide_t shifted;
    wide_t clamped;

    always_comb begin
        biased = sext(WIDE_W'(acc), ACC_W);
        if (shift != '0) begin
            biased = biased + (wide_t'(1) <<< (shift - 1'b1));
        end
        // Rounding bias can push past the accumulator range; clip it back
        // so the shifted value matches an ACC_W-bit saturating add.
        rounded = sat_signed(biased, ACC_W);
        shifted = rounded >>> shift;
        if (relu && shifted[WIDE_W-1]) begin
            shifted = '0;
        end
        clamped = sat_signed(shifted, OUT_W);
        result  = OUT_W'(clamped);
    end

endmodule

// File: rtl/addertree_result_accumulator.sv
// ----------------------------------------------------------------------------
// addertree_result_accumulator
// Resolves carry-save vectors from the final compressor stage, accumulates
// them over a kernel window with saturation, requantises the window total and
// presents one result per window on a valid/ready output.
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid/in_ready    : input handshake (in_ready = global advance)
//   in_sum, in_carry     : carry-save vectors, IN_W bits two's complement
//   in_last              : beat closes the current window
//   cfg_shift, cfg_relu  : requant controls, used on the closing beat
//   out_valid/out_ready  : output handshake
//   out_data             : requantised signed result
//   out_ovf              : accumulator saturated during the window
//   out_beats            : beats in the window, saturating at all-ones
// ----------------------------------------------------------------------------
module addertree_result_accumulator
    import npu_acc_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned OUT_W = DEF_OUT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic        [IN_W-1:0]    in_sum,
    input  logic        [IN_W-1:0]    in_carry,
    input  logic                      in_last,
    input  logic        [SHIFT_W-1:0] cfg_shift,
    input  logic                      cfg_relu,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OUT_W-1:0]   out_data,
    output logic                      out_ovf,
    output logic        [CNT_W-1:0]   out_beats
);

    logic                    en;
    logic                    close;

    logic                    a_val;
    logic                    a_last;
    logic signed [IN_W:0]    a_res;
    logic signed [IN_W:0]    in_res;

    logic signed [ACC_W-1:0] acc;
    logic                    first;
    logic                    ovf_sticky;
    logic [CNT_W-1:0]        cnt;

    wide_t                   sum_wide;
    wide_t                   sum_sat;
    logic                    sat_hit;
    logic signed [ACC_W-1:0] acc_next;
    logic                    ovf_next;
    logic [CNT_W-1:0]        cnt_next;
    logic signed [OUT_W-1:0] rq_result;

    // Whole pipe advances together; it freezes only while a result waits.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign close    = en && a_val && a_last;

    assign in_res = (IN_W + 1)'(sext(WIDE_W'(in_sum), IN_W) + sext(WIDE_W'(in_carry), IN_W));

    always_comb begin
        sum_wide = sext(WIDE_W'(a_res), IN_W + 1);
        if (!first) begin
            sum_wide = sum_wide + sext(WIDE_W'(acc), ACC_W);
        end
        sum_sat  = sat_signed(sum_wide, ACC_W);
        sat_hit  = (sum_sat != sum_wide);
        acc_next = ACC_W'(sum_sat);
        ovf_next = (first ? 1'b0 : ovf_sticky) | sat_hit;
        cnt_next = first ? '0 : cnt;
        if (cnt_next != '1) begin
            cnt_next = cnt_next + 1'b1;
        end
    end

    acc_requant #(
        .ACC_W(ACC_W),
        .OUT_W(OUT_W)
    ) u_requant (
        .acc    (acc_next),
        .shift  (cfg_shift),
        .relu   (cfg_relu),
        .result (rq_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_val      <= 1'b0;
            a_last     <= 1'b0;
            a_res      <= '0;
            acc        <= '0;
            first      <= 1'b1;
            ovf_sticky <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ovf    <= 1'b0;
            out_beats  <= '0;
        end else begin
            if (en) begin
                a_val <= in_valid;
                if (in_valid) begin
                    a_res  <= in_res;
                    a_last <= in_last;
                end
                if (a_val) begin
                    acc        <= acc_next;
                    ovf_sticky <= ovf_next;
                    cnt        <= cnt_next;
                    first      <= a_last;
                end
            end
            // A close in the same edge as a consume reloads instead of clearing.
            if (close) begin
                out_valid <= 1'b1;
                out_data  <= rq_result;
                out_ovf   <= ovf_next;
                out_beats <= cnt_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_addertree_result_accumulator.sv
// ----------------------------------------------------------------------------
// tb_addertree_result_accumulator
// Self-checking bench: directed windows with hand-computed results plus
// randomized windows with random input gaps and output backpressure, all
// checked against a window-level arithmetic model.
// ----------------------------------------------------------------------------
module tb_addertree_result_accumulator;

    localparam longint ACC_MAX = 64'sd2147483647;
    localparam longint ACC_MIN = -64'sd2147483648;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic        [19:0] in_sum;
    logic        [19:0] in_carry;
    logic               in_last;
    logic        [4:0]  cfg_shift;
    logic               cfg_relu;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [7:0]  out_data;
    logic               out_ovf;
    logic        [15:0] out_beats;

    addertree_result_accumulator #(
        .IN_W (20),
        .ACC_W(32),
        .OUT_W(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .in_last   (in_last),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_beats (out_beats)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit ovf;
        int beats;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   fire_count = 0;
    int   cycles = 0;
    int   ready_pct = 100;
    int   hold0 = 0;
    bit   pending = 0;
    bit   pending_nxt = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic longint sx20(input logic [19:0] v);
        return longint'(signed'(v));
    endfunction

    // Window result from the stated rules: round half-up with a saturated add,
    // floor shift, optional ReLU, clamp to 8-bit signed.
    function automatic int model_requant(input longint acc, input int sh, input bit rl);
        longint r;
        r = acc + ((sh != 0) ? (longint'(1) << (sh - 1)) : 64'sd0);
        if (r > ACC_MAX) r = ACC_MAX;
        r = r >>> sh;
        if (rl && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    // Output backpressure source.
    always @(negedge clk) begin
        if (hold0 > 0) begin
            out_ready = 1'b0;
            hold0--;
        end else begin
            out_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Compare process: handshake rule, stall stability, result ordering/content.
    bit                prev_stall = 0;
    logic signed [7:0] prev_data;
    logic              prev_ovf;
    logic [15:0]       prev_beats;

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (reset) begin
            prev_stall = 0;
        end else begin
            check("in_ready", in_ready, (!out_valid || out_ready));
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_ovf", out_ovf, prev_ovf);
                check("stall_beats", out_beats, prev_beats);
            end
            if (out_valid && out_ready) begin
                fire_count++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_result: actual data %0d, required no result", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_ovf", out_ovf, e.ovf);
                    check("out_beats", out_beats, e.beats);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_ovf   = out_ovf;
            prev_beats = out_beats;
        end
    end

    // One input cycle: drive at negedge, decide acceptance just after.
    task automatic cyc(input bit v, input logic [19:0] s, input logic [19:0] c,
                       input bit l, output bit ok);
        @(negedge clk);
        pending  = pending_nxt;
        in_valid = v;
        in_sum   = s;
        in_carry = c;
        in_last  = l;
        #1;
        cycles++;
        ok = v && in_ready;
        pending_nxt = in_ready ? (v && l) : pending;
    endtask

    // Change the requant controls only once no window close is outstanding.
    task automatic apply_cfg(input logic [4:0] sh, input bit rl);
        if (sh == cfg_shift && rl == cfg_relu) return;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            pending  = pending_nxt;
            in_valid = 1'b0;
            if (!pending) begin
                cfg_shift = sh;
                cfg_relu  = rl;
            end
            #1;
            cycles++;
            pending_nxt = in_ready ? 1'b0 : pending;
            if (!pending) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL cfg_wait: close still pending, required none");
    endtask

    task automatic send_window(input int nb, input bit fixed,
                               input logic [19:0] fs, input logic [19:0] fc,
                               input logic [4:0] sh, input bit rl, input int gap_pct,
                               input bit pin, input int pd, input bit po, input int pbeats);
        longint      acc = 0;
        bit          ovf = 0;
        int          cnt = 0;
        bit          ok;
        exp_t        e;
        logic [19:0] s;
        logic [19:0] c;
        apply_cfg(sh, rl);
        for (int b = 0; b < nb; b++) begin
            s = fixed ? fs : 20'($urandom);
            c = fixed ? fc : 20'($urandom);
            for (int g = 0; g < 20 && $urandom_range(99) < gap_pct; g++) cyc(1'b0, s, c, 1'b0, ok);
            ok = 0;
            for (int t = 0; t < 1000 && !ok; t++) cyc(1'b1, s, c, (b == nb - 1), ok);
            if (!ok) begin
                $display("FAIL accept_timeout: beat %0d never accepted, required acceptance", b);
                $fatal(1, "input stalled");
            end
            acc = acc + sx20(s) + sx20(c);
            if (acc > ACC_MAX) begin acc = ACC_MAX; ovf = 1; end
            if (acc < ACC_MIN) begin acc = ACC_MIN; ovf = 1; end
            if (cnt < 65535) cnt++;
        end
        e.data  = model_requant(acc, int'(sh), rl);
        e.ovf   = ovf;
        e.beats = cnt;
        if (pin) begin
            check("model_pin_data", e.data, pd);
            check("model_pin_ovf", e.ovf, po);
            check("model_pin_beats", e.beats, pbeats);
        end
        exp_q.push_back(e);
    endtask

    task automatic drain();
        bit ok;
        for (int t = 0; t < 2000 && exp_q.size() != 0; t++) cyc(1'b0, '0, '0, 1'b0, ok);
        check("drain_outstanding", exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_ovf"}, out_ovf, 0);
        check({tag, "_out_beats"}, out_beats, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          fc0;
        int          c0;
        logic [4:0]  rsh;
        bit          rrl;

        reset = 1'b1;  in_valid = 1'b0; in_sum = '0; in_carry = '0; in_last = 1'b0;
        cfg_shift = '0; cfg_relu = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // 1: reset in the middle of a window discards the partial sum
        cyc(1'b1, 20'd700, 20'd11, 1'b0, ok);
        cyc(1'b1, 20'd900, 20'd13, 1'b0, ok);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; pending_nxt = 0;
        send_window(1, 1, 20'd5, 20'd3, 5'd0, 0, 0, 1, 8, 0, 1);

        // 2: four beats of 100 + (-40), shift 2 -> 60, with latency check
        send_window(4, 1, 20'd100, 20'(-40), 5'd2, 0, 0, 1, 60, 0, 4);
        cyc(1'b0, '0, '0, 1'b0, ok);
        check("latency_edge1", out_valid, 0);
        cyc(1'b0, '0, '0, 1'b0, ok);
        check("latency_edge2", out_valid, 1);

        // 3: rounding, ReLU and clamping
        send_window(1, 1, 20'd6, 20'd0, 5'd2, 0, 0, 1, 2, 0, 1);
        send_window(1, 1, 20'(-6), 20'd0, 5'd2, 0, 0, 1, -1, 0, 1);
        send_window(1, 1, 20'd1000, 20'd0, 5'd0, 0, 0, 1, 127, 0, 1);
        send_window(1, 1, 20'(-1000), 20'd0, 5'd0, 1, 0, 1, 0, 0, 1);
        send_window(1, 1, 20'(-1000), 20'd0, 5'd0, 0, 0, 1, -128, 0, 1);

        // 4: backpressure while the next window streams, then back-to-back
        send_window(1, 0, '0, '0, 5'd3, 0, 0, 0, 0, 0, 0);
        hold0 = 5;
        send_window(3, 0, '0, '0, 5'd3, 0, 0, 0, 0, 0, 0);
        send_window(3, 0, '0, '0, 5'd3, 0, 0, 0, 0, 0, 0);
        drain();
        fc0 = fire_count;
        c0  = cycles;
        for (int w = 0; w < 20; w++) send_window(1, 0, '0, '0, 5'd3, 0, 0, 0, 0, 0, 0);
        check("b2b_accept_cycles", cycles - c0, 20);
        repeat (3) cyc(1'b0, '0, '0, 1'b0, ok);
        check("b2b_results", fire_count - fc0, 20);

        // 5: long windows, positive and negative saturation, sticky flag reset
        send_window(3000, 1, 20'h3FFFF, 20'h3FFFF, 5'd0, 0, 0, 1, 127, 0, 3000);
        send_window(3000, 1, 20'h7FFFF, 20'h7FFFF, 5'd25, 0, 0, 1, 63, 1, 3000);
        send_window(1, 1, 20'd5, 20'd3, 5'd25, 0, 0, 1, 0, 0, 1);
        send_window(2500, 1, 20'h80000, 20'h80000, 5'd25, 0, 0, 1, -64, 1, 2500);
        send_window(1, 1, 20'(-1000), 20'd0, 5'd25, 0, 0, 1, 0, 0, 1);
        drain();

        // 6: random windows with random gaps and backpressure
        ready_pct = 80;
        rsh = 5'd4;
        rrl = 0;
        for (int w = 0; w < 10000; w++) begin
            if ($urandom_range(1) == 1) begin
                rsh = 5'($urandom_range(31));
                rrl = 1'($urandom_range(1));
            end
            send_window(1 + int'($urandom_range(3)), 0, '0, '0, rsh, rrl, 20, 0, 0, 0, 0);
        end
        ready_pct = 100;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
